rv32i_test_ctrl: RTL and testbench
==================================

RV32I_TEST_CTRL -- requirements
Module: rv32i_test_ctrl

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1, number of monitored cores (1..8).
REQ-002 SHALL have parameter RST_CYCLES, default 10, core reset pulse length in clk cycles (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000, max RUN cycles before timeout (>=1, < 2**CNT_W).
REQ-004 SHALL have parameter CNT_W, default 16, width of cycle and test counters.
REQ-005 SHALL have parameter PASS_VALUE, default 32'h1, gp (x3) value that means pass.
REQ-006 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-008 SHALL have port start, input, 1, level request to run one test (4-phase handshake).
REQ-009 SHALL have port abort, input, 1, synchronous cancel of the test in progress.
REQ-010 SHALL have port ecall, input, NUM_HARTS, per-hart ecall-executing indication.
REQ-011 SHALL have port gp_value, input, 32*NUM_HARTS, per-hart x3 value; hart h occupies bits [32h+31:32h].
REQ-012 SHALL have port core_rst_n, output, 1, active-low reset driven to all cores.
REQ-013 SHALL have port busy, output, 1, high in RESET and RUN.
REQ-014 SHALL have port done, output, 1, high in DONE.
REQ-015 SHALL have port status, output, 2*NUM_HARTS, per hart: 0 pending, 1 pass, 2 fail, 3 timeout.
REQ-016 SHALL have port pass_all, output, 1, high in DONE only when every hart status is pass.
REQ-017 SHALL have port cycle_count, output, CNT_W, RUN cycles elapsed in the current or last test.
REQ-018 SHALL have port test_count, output, CNT_W, number of completed tests (DONE entries).

Function
REQ-019 SHALL implement FSM states IDLE, RESET, RUN, DONE.
REQ-020 IDLE: core_rst_n=0; on start=1 SHALL clear status to pending and cycle_count to 0, then go to RESET.
REQ-021 RESET: core_rst_n=0 for exactly RST_CYCLES cycles, then RUN; core_rst_n SHALL be registered (glitch-free).
REQ-022 RUN: core_rst_n=1; cycle_count SHALL increment by 1 each RUN cycle, saturating at all-ones.
REQ-023 RUN: a pending hart h with ecall[h]=1 SHALL latch status pass if gp_value[h]==PASS_VALUE, else fail.
REQ-024 Once latched, a hart status SHALL not change until the next start in IDLE; later ecalls are ignored.
REQ-025 RUN SHALL exit to DONE on the cycle after the last pending hart latches.
REQ-026 On RUN cycle with cycle_count==TIMEOUT_CYCLES-1, harts still pending without ecall SHALL become timeout, and the FSM SHALL go to DONE.
REQ-027 ecall coinciding with the terminal timeout cycle SHALL take priority (pass/fail, not timeout).
REQ-028 On DONE entry test_count SHALL increment by 1, wrapping modulo 2**CNT_W.
REQ-029 DONE: core_rst_n=0, done=1, status/cycle_count held; SHALL return to IDLE when start=0.
REQ-030 start held high through DONE SHALL not begin a new test until it drops and reasserts.
REQ-031 start in RESET or RUN SHALL be ignored.
REQ-032 abort=1 in RESET or RUN SHALL go to IDLE next cycle, status cleared to pending, test_count unchanged; abort in IDLE/DONE ignored; abort outranks ecall and timeout.
REQ-033 pass_all SHALL be 0 outside DONE.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, core_rst_n=0, busy=0, done=0, status=0, pass_all=0, cycle_count=0, test_count=0, regardless of clk.
REQ-035 Reset asserted mid-RESET or mid-RUN SHALL discard the test; after release the block SHALL wait in IDLE for a new start rising edge.

Verification (NUM_HARTS=2, RST_CYCLES=10, TIMEOUT_CYCLES=20)
REQ-036 start=1; core_rst_n low 10 cycles after RESET entry; ecall=2'b11, gp=1,1 at cycle_count 5 -> status=4'b0101, pass_all=1, test_count=1, cycle_count=6.
REQ-037 hart0 ecall gp=1 at cycle 3, hart1 ecall gp=7 at cycle 8 -> status=4'b1001 (hart1 fail, hart0 pass), pass_all=0, DONE after cycle 8.
REQ-038 hart0 ecall gp=1 at cycle 2, hart1 never -> hart1 timeout at cycle_count 19, status=4'b1101, DONE entered, cycle_count=20.
REQ-039 hart1 ecall gp=1 exactly at cycle_count 19 -> hart1 pass, not timeout.
REQ-040 abort at RUN cycle 4 -> IDLE next cycle, status=0, test_count unchanged; start held high through DONE -> no second test until start toggles.
REQ-041 rst_n pulsed low asynchronously mid-RUN -> all outputs at reset values without a clk edge; 2**CNT_W completions wrap test_count to 0.

Source files
------------

// File: rtl/rv32i_test_ctrl.sv
// Test sequencer for RV32I cores: pulses core reset, runs the cores, and
// collects per-hart pass/fail/timeout verdicts from ecall and gp (x3).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | cores held in reset, waiting for a fresh start request
// S_RESET | core reset pulse, RST_CYCLES long
// S_RUN   | cores released, watching ecall/gp and the timeout counter
// S_DONE  | verdicts held, waiting for start to drop
module rv32i_test_ctrl #(
    parameter int          NUM_HARTS      = 1,
    parameter int          RST_CYCLES     = 10,
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter int          CNT_W          = 16,
    parameter logic [31:0] PASS_VALUE     = 32'h1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_HARTS-1:0]   ecall,
    input  logic [32*NUM_HARTS-1:0] gp_value,
    output logic                   core_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic [2*NUM_HARTS-1:0] status,
    output logic                   pass_all,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]       test_count
);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0]    RST_LOAD = RW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_PEND = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;
    localparam logic [1:0] ST_TMO  = 2'd3;

    state_t                 state_q, state_d;
    logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
    logic [2*NUM_HARTS-1:0] status_q, status_d;
    logic [CNT_W-1:0]       cyc_q, cyc_d;
    logic [CNT_W-1:0]       tcnt_q, tcnt_d;
    logic                   core_rst_n_q, core_rst_n_d;
    // armed_q goes high once start has been seen low, so a level held across
    // DONE, abort or reset release cannot launch a second test.
    logic                   armed_q, armed_d;

    logic [2*NUM_HARTS-1:0] st_run;
    logic                   any_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            status_q     <= '0;
            cyc_q        <= '0;
            tcnt_q       <= '0;
            core_rst_n_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            status_q     <= status_d;
            cyc_q        <= cyc_d;
            tcnt_q       <= tcnt_d;
            core_rst_n_q <= core_rst_n_d;
            armed_q      <= armed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        status_d  = status_q;
        cyc_d     = cyc_q;
        tcnt_d    = tcnt_q;
        armed_d   = start ? armed_q : 1'b1;
        st_run    = status_q;
        any_pend  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && armed_q) begin
                    state_d   = S_RESET;
                    status_d  = '0;
                    cyc_d     = '0;
                    rst_cnt_d = RST_LOAD;
                    armed_d   = 1'b0;
                end
            end
            S_RESET: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    status_d = '0;
                end else if (rst_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RW'(1);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    status_d = '0;
                end else begin
                    if (cyc_q != '1) begin
                        cyc_d = cyc_q + CNT_W'(1);
                    end
                    for (int h = 0; h < NUM_HARTS; h++) begin
                        if (st_run[2*h +: 2] == ST_PEND && ecall[h]) begin
                            st_run[2*h +: 2] = (gp_value[32*h +: 32] == PASS_VALUE) ?
                                               ST_PASS : ST_FAIL;
                        end
                    end
                    for (int h = 0; h < NUM_HARTS; h++) begin
                        if (st_run[2*h +: 2] == ST_PEND) begin
                            any_pend = 1'b1;
                        end
                    end
                    // An ecall on the terminal cycle has already latched above,
                    // so only harts that stayed silent become timeouts.
                    if (any_pend && cyc_q == TC_LAST) begin
                        for (int h = 0; h < NUM_HARTS; h++) begin
                            if (st_run[2*h +: 2] == ST_PEND) begin
                                st_run[2*h +: 2] = ST_TMO;
                            end
                        end
                        any_pend = 1'b0;
                    end
                    status_d = st_run;
                    if (!any_pend) begin
                        state_d = S_DONE;
                        tcnt_d  = tcnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        core_rst_n_d = (state_d == S_RUN);
    end

    always_comb begin
        pass_all = (state_q == S_DONE);
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (status_q[2*h +: 2] != ST_PASS) begin
                pass_all = 1'b0;
            end
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign busy        = (state_q == S_RESET) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign status      = status_q;
    assign cycle_count = cyc_q;
    assign test_count  = tcnt_q;

endmodule

// File: tb/tb_rv32i_test_ctrl.sv
// Scoreboard bench for rv32i_test_ctrl: a plan-level model predicts each test's
// verdict; a monitor pops and compares on every DONE entry or abort.
module tb_rv32i_test_ctrl;

    localparam int NH    = 2;
    localparam int RSTC  = 10;
    localparam int TMO   = 20;
    localparam int CW    = 5;
    localparam int NEVER = 99;

    logic            clk = 1'b0;
    logic            rst_n, start, abort;
    logic [NH-1:0]   ecall;
    logic [32*NH-1:0] gp_value;
    logic            core_rst_n, busy, done, pass_all;
    logic [2*NH-1:0] status;
    logic [CW-1:0]   cycle_count, test_count;

    rv32i_test_ctrl #(
        .NUM_HARTS(NH), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO),
        .CNT_W(CW), .PASS_VALUE(32'h1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ecall(ecall), .gp_value(gp_value), .core_rst_n(core_rst_n),
        .busy(busy), .done(done), .status(status), .pass_all(pass_all),
        .cycle_count(cycle_count), .test_count(test_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_abort;
        logic [3:0]  st;
        logic [4:0]  cc;
        logic [4:0]  tc;
        bit          pa;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_tc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor
    bit prev_busy = 0, prev_done = 0, prev_crn = 0;
    int rc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_busy = 0; prev_done = 0; prev_crn = 0;
        end else begin
            if (busy && !prev_busy) rc = 0;
            if (busy && !core_rst_n) rc++;
            if (core_rst_n && !prev_crn) chk("rst_len", rc, RSTC);
            if ((done && !prev_done) || (prev_busy && !busy && !done)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind", {31'd0, !done}, {31'd0, e.is_abort});
                    chk("status", status, e.st);
                    chk("test_count", test_count, e.tc);
                    chk("pass_all", pass_all, e.pa);
                    if (!e.is_abort) chk("cycle_count", cycle_count, e.cc);
                end
            end
            prev_busy = busy; prev_done = done; prev_crn = core_rst_n;
        end
    end

    // c: cycle_count at which hart first raises ecall; g: gp at that cycle.
    task automatic run_test(input int c0, input int c1, input logic [31:0] g0,
                            input logic [31:0] g1, input int ab_run, input bit ab_rst);
        int cs[NH];
        logic [31:0] gs[NH];
        int endc, k;
        bit all;
        exp_t e;
        cs[0] = c0; cs[1] = c1; gs[0] = g0; gs[1] = g1;
        all  = (c0 <= TMO-1) && (c1 <= TMO-1);
        endc = all ? ((c0 > c1) ? c0 : c1) : TMO-1;
        e.is_abort = ab_rst || (ab_run >= 0 && ab_run <= endc);
        e.st = 4'd0; e.cc = 5'd0; e.pa = 0;
        if (!e.is_abort) begin
            for (int h = 0; h < NH; h++)
                e.st[2*h +: 2] = (cs[h] <= TMO-1) ? ((gs[h] == 32'h1) ? 2'd1 : 2'd2) : 2'd3;
            e.cc = 5'(endc + 1);
            e.pa = (e.st == 4'b0101);
            model_tc = (model_tc + 1) % (1 << CW);
        end
        e.tc = 5'(model_tc);
        exp_q.push_back(e);

        @(posedge clk); #1 start = 1;
        @(posedge clk); #1;
        k = 0;
        while (busy && !core_rst_n && k < 30) begin
            ecall = NH'($urandom);
            abort = ab_rst && (k == 5);
            @(posedge clk); #1;
            abort = 0;
            k++;
        end
        ecall = '0;
        k = 0;
        while (busy && core_rst_n && !done && k < 40) begin
            for (int h = 0; h < NH; h++) begin
                ecall[h] = (k >= cs[h]);
                gp_value[32*h +: 32] = (k == cs[h]) ? gs[h] : $urandom;
            end
            abort = (k == ab_run);
            @(posedge clk); #1;
            abort = 0;
            k++;
        end
        ecall = '0;
        if (busy) chk("wait_bound", 1, 0);
        if (done) begin
            repeat (3) begin
                abort = 1;
                @(posedge clk); #1;
            end
            abort = 0;
            chk("done_hold", {31'd0, done}, 1);
            chk("tc_hold", test_count, 32'(model_tc));
            start = 0;
            @(posedge clk); #1;
            chk("idle_ret", {30'd0, done, busy}, 0);
            chk("pass_all_idle", {31'd0, pass_all}, 0);
        end else begin
            repeat (3) @(posedge clk);
            #1 chk("no_restart", {31'd0, busy}, 0);
            start = 0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, c1, ab;
        logic [31:0] g0, g1;
        rst_n = 0; start = 0; abort = 0; ecall = '0; gp_value = '0;
        #12;
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 0);
        chk("rst_busy_done", {30'd0, busy, done}, 0);
        chk("rst_status", status, 0);
        chk("rst_counts", {cycle_count, test_count}, 0);
        chk("rst_pass_all", {31'd0, pass_all}, 0);
        @(posedge clk); #1 rst_n = 1;

        run_test(5, 5, 32'h1, 32'h1, -1, 0);
        run_test(3, 8, 32'h1, 32'h7, -1, 0);
        run_test(2, NEVER, 32'h1, 32'h1, -1, 0);
        run_test(2, 19, 32'h1, 32'h1, -1, 0);
        run_test(NEVER, NEVER, 32'h1, 32'h1, 4, 0);
        run_test(NEVER, NEVER, 32'h1, 32'h1, -1, 1);
        run_test(20, 19, 32'h1, 32'h3, -1, 0);
        run_test(0, 0, 32'h0, 32'h1, 0, 0);

        for (int i = 0; i < 30; i++) begin
            c0 = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 24);
            c1 = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 24);
            g0 = $urandom_range(0, 1) ? 32'h1 : $urandom;
            g1 = $urandom_range(0, 1) ? 32'h1 : $urandom;
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : -1;
            run_test(c0, c1, g0, g1, ab, 0);
        end

        // Asynchronous reset mid-RUN, with start held across release.
        @(posedge clk); #1 start = 1;
        repeat (15) @(posedge clk);
        #1 chk("mid_run", {30'd0, busy, core_rst_n}, 2'b11);
        #2 rst_n = 0;
        #1;
        chk("ar_core_rst_n", {31'd0, core_rst_n}, 0);
        chk("ar_busy_done", {30'd0, busy, done}, 0);
        chk("ar_status", status, 0);
        chk("ar_counts", {cycle_count, test_count}, 0);
        chk("ar_pass_all", {31'd0, pass_all}, 0);
        exp_q.delete();
        model_tc = 0;
        @(posedge clk); #1 rst_n = 1;
        repeat (3) @(posedge clk);
        #1 chk("ar_no_start", {31'd0, busy}, 0);
        start = 0;

        for (int i = 0; i < (1 << CW); i++)
            run_test(0, 0, 32'h1, 32'h1, -1, 0);
        chk("tc_wrap", test_count, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
